// File: rtl/rv32_ctrl_pkg.sv
// Shared types and constants for the RV32I front end and control-word pipeline.
package rv32_ctrl_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned CWORD_W = 23;

    localparam int unsigned TYPE_LSB = 0;
    localparam int unsigned FUN3_LSB = 4;
    localparam int unsigned FUN7_BIT = 7;
    localparam int unsigned RD_LSB   = 8;
    localparam int unsigned RS1_LSB  = 13;
    localparam int unsigned RS2_LSB  = 18;

    localparam int unsigned Z_BIT = 3;
    localparam int unsigned C_BIT = 2;
    localparam int unsigned N_BIT = 1;
    localparam int unsigned V_BIT = 0;

    localparam logic [3:0] T_LOAD   = 4'd0;
    localparam logic [3:0] T_IMM    = 4'd1;
    localparam logic [3:0] T_STORE  = 4'd2;
    localparam logic [3:0] T_REG    = 4'd3;
    localparam logic [3:0] T_LUI    = 4'd4;
    localparam logic [3:0] T_AUIPC  = 4'd5;
    localparam logic [3:0] T_BRANCH = 4'd6;
    localparam logic [3:0] T_JALR   = 4'd7;
    localparam logic [3:0] T_JAL    = 4'd8;

    localparam logic [CWORD_W-1:0] NOP_CWORD = 23'h000001;
    localparam logic [XLEN-1:0]    NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [4:0] rd;
        logic       fun7;
        logic [2:0] fun3;
        logic [3:0] itype;
    } cword_t;

    // True when c writes architectural register r (x0 never counts).
    function automatic logic writes_reg(cword_t c, logic [4:0] r);
        return (r != 5'd0) && (c.rd == r) && (c.itype != T_STORE) && (c.itype != T_BRANCH);
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I decode: instruction word to control word, immediate and illegal flag.
module instr_decoder
    import rv32_ctrl_pkg::*;
(
    input  logic [XLEN-1:0]    instr,
    output logic [CWORD_W-1:0] cword,
    output logic [XLEN-1:0]    imm,
    output logic               illegal
);

    logic [3:0] itype;
    logic [2:0] fun3;
    logic       fun7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;

    always_comb begin
        itype   = T_IMM;
        illegal = 1'b0;
        case (instr[6:0])
            7'b0000011: itype = T_LOAD;
            7'b0010011: itype = T_IMM;
            7'b0100011: itype = T_STORE;
            7'b0110011: itype = T_REG;
            7'b0110111: itype = T_LUI;
            7'b0010111: itype = T_AUIPC;
            7'b1100011: itype = T_BRANCH;
            7'b1100111: itype = T_JALR;
            7'b1101111: itype = T_JAL;
            default:    illegal = 1'b1;
        endcase
    end

    // Unused register slots are forced to x0 so hazard and forwarding logic never see phantom operands.
    always_comb begin
        fun3 = instr[14:12];
        fun7 = 1'b0;
        rd   = instr[11:7];
        rs1  = instr[19:15];
        rs2  = 5'd0;
        if (itype == T_REG || (itype == T_IMM && fun3 == 3'b101)) fun7 = instr[30];
        if (itype == T_STORE || itype == T_BRANCH) rd = 5'd0;
        if (itype == T_LUI || itype == T_AUIPC || itype == T_JAL) rs1 = 5'd0;
        if (itype == T_REG || itype == T_STORE || itype == T_BRANCH) rs2 = instr[24:20];
    end

    always_comb begin
        imm = '0;
        case (itype)
            T_LOAD, T_IMM, T_JALR: imm = {{20{instr[31]}}, instr[31:20]};
            T_STORE:               imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            T_BRANCH:              imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            T_LUI, T_AUIPC:        imm = {instr[31:12], 12'b0};
            T_JAL:                 imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:               imm = '0;
        endcase
        if (illegal) imm = '0;
    end

    assign cword = illegal ? NOP_CWORD
                 : ((CWORD_W'(rs2)   << RS2_LSB)  | (CWORD_W'(rs1)  << RS1_LSB) |
                    (CWORD_W'(rd)    << RD_LSB)   | (CWORD_W'(fun7) << FUN7_BIT) |
                    (CWORD_W'(fun3)  << FUN3_LSB) | (CWORD_W'(itype) << TYPE_LSB));

endmodule

// File: rtl/pipeline_control.sv
// RV32I fetch, IF/ID, decode and control-word pipeline with ID hazard stalls and EX-stage redirects.
module pipeline_control
    import rv32_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     IMEM_AW  = 8
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_rdata,
    output logic [CWORD_W-1:0] cwordID,
    output logic [CWORD_W-1:0] cwordEX,
    output logic [CWORD_W-1:0] cwordMEM,
    output logic [CWORD_W-1:0] cwordWB,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    immEX,
    output logic [XLEN-1:0]    immMEM,
    input  logic [XLEN-1:0]    r_for_pc,
    input  logic [3:0]         funit_ZCNVFlags,
    output logic               illegal
);

    logic [XLEN-1:0]    pc_if;
    logic [XLEN-1:0]    instr_id;
    logic [XLEN-1:0]    pc_id;
    logic [XLEN-1:0]    pc_ex;
    logic [XLEN-1:0]    imm_ex;
    logic [XLEN-1:0]    imm_mem;
    cword_t             id_cw;
    cword_t             ex_cw;
    cword_t             mem_cw;
    cword_t             wb_cw;
    logic               illegal_q;

    logic [CWORD_W-1:0] dec_cword;
    logic [XLEN-1:0]    dec_imm;
    logic               dec_illegal;

    logic               taken_c;
    logic               redirect_c;
    logic [XLEN-1:0]    target_c;
    logic               load_use_c;
    logic               store_dep_c;
    logic               jalr_dep_c;
    logic               stall_c;

    instr_decoder u_dec (
        .instr   (instr_id),
        .cword   (dec_cword),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    assign id_cw = cword_t'(dec_cword);

    // Branch condition and redirect target for the instruction in EX.
    always_comb begin
        taken_c = 1'b0;
        case (ex_cw.fun3)
            3'b000:  taken_c = funit_ZCNVFlags[Z_BIT];
            3'b001:  taken_c = !funit_ZCNVFlags[Z_BIT];
            3'b100:  taken_c = funit_ZCNVFlags[N_BIT] ^ funit_ZCNVFlags[V_BIT];
            3'b101:  taken_c = !(funit_ZCNVFlags[N_BIT] ^ funit_ZCNVFlags[V_BIT]);
            3'b110:  taken_c = !funit_ZCNVFlags[C_BIT];
            3'b111:  taken_c = funit_ZCNVFlags[C_BIT];
            default: taken_c = 1'b0;
        endcase
        redirect_c = 1'b0;
        target_c   = pc_ex + imm_ex;
        case (ex_cw.itype)
            T_BRANCH: redirect_c = taken_c;
            T_JAL:    redirect_c = 1'b1;
            T_JALR: begin
                redirect_c = 1'b1;
                target_c   = (r_for_pc + imm_ex) & ~32'd1;
            end
            default:  redirect_c = 1'b0;
        endcase
    end

    // Loads forward only from WB; store data and jalr base are not forwarded at all.
    always_comb begin
        load_use_c = 1'b0;
        if (ex_cw.itype == T_LOAD && (writes_reg(ex_cw, id_cw.rs1) || writes_reg(ex_cw, id_cw.rs2)))
            load_use_c = 1'b1;
        if (mem_cw.itype == T_LOAD && (writes_reg(mem_cw, id_cw.rs1) || writes_reg(mem_cw, id_cw.rs2)))
            load_use_c = 1'b1;
        store_dep_c = (id_cw.itype == T_STORE) &&
                      (writes_reg(ex_cw, id_cw.rs2) || writes_reg(mem_cw, id_cw.rs2) ||
                       writes_reg(wb_cw, id_cw.rs2));
        jalr_dep_c  = (id_cw.itype == T_JALR) &&
                      (writes_reg(ex_cw, id_cw.rs1) || writes_reg(mem_cw, id_cw.rs1) ||
                       writes_reg(wb_cw, id_cw.rs1));
        stall_c     = load_use_c || store_dep_c || jalr_dep_c;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_if     <= RESET_PC;
            instr_id  <= NOP_INSTR;
            pc_id     <= '0;
            ex_cw     <= cword_t'(NOP_CWORD);
            pc_ex     <= '0;
            imm_ex    <= '0;
            mem_cw    <= cword_t'(NOP_CWORD);
            imm_mem   <= '0;
            wb_cw     <= cword_t'(NOP_CWORD);
            illegal_q <= 1'b0;
        end else begin
            mem_cw    <= ex_cw;
            imm_mem   <= imm_ex;
            wb_cw     <= mem_cw;
            pc_ex     <= pc_id;
            illegal_q <= dec_illegal && !redirect_c;
            if (redirect_c) begin
                pc_if    <= target_c;
                instr_id <= NOP_INSTR;
                pc_id    <= target_c;
                ex_cw    <= cword_t'(NOP_CWORD);
                imm_ex   <= '0;
            end else if (stall_c) begin
                ex_cw    <= cword_t'(NOP_CWORD);
                imm_ex   <= '0;
            end else begin
                pc_if    <= pc_if + 32'd4;
                instr_id <= imem_rdata;
                pc_id    <= pc_if;
                ex_cw    <= id_cw;
                imm_ex   <= dec_imm;
            end
        end
    end

    assign imem_addr = pc_if[IMEM_AW+1:2];
    assign cwordID   = dec_cword;
    assign cwordEX   = ex_cw;
    assign cwordMEM  = mem_cw;
    assign cwordWB   = wb_cw;
    assign pc        = pc_ex;
    assign immEX     = imm_ex;
    assign immMEM    = imm_mem;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed and randomized checks of pipeline_control against an instruction-flow reference model.
module tb_pipeline_control;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [6:0]  OPS [9] = '{7'h03, 7'h13, 7'h23, 7'h33, 7'h37, 7'h17, 7'h63, 7'h67, 7'h6F};

    typedef struct packed {
        logic        known;
        logic [3:0]  typ;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } dec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [22:0] cwordID, cwordEX, cwordMEM, cwordWB;
    logic [31:0] pc, immEX, immMEM, r_for_pc;
    logic [3:0]  funit_ZCNVFlags;
    logic        illegal;
    logic [31:0] imem [256];

    int total = 0;
    int bad   = 0;

    // Reference model: the pipeline carries raw instruction words; bubbles are NOP words.
    logic [31:0] m_pc_if, m_id_w, m_id_pc, m_ex_w, m_ex_pc, m_mem_w, m_wb_w;
    logic        m_id_v, m_ex_v, m_ill;

    always #5 clk = ~clk;
    assign imem_rdata = imem[imem_addr];

    pipeline_control #(.RESET_PC(32'h0), .IMEM_AW(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .cwordID         (cwordID),
        .cwordEX         (cwordEX),
        .cwordMEM        (cwordMEM),
        .cwordWB         (cwordWB),
        .pc              (pc),
        .immEX           (immEX),
        .immMEM          (immMEM),
        .r_for_pc        (r_for_pc),
        .funit_ZCNVFlags (funit_ZCNVFlags),
        .illegal         (illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic dec_t ref_dec(input logic [31:0] w);
        dec_t d;
        d     = '0;
        d.typ = 4'd1;
        for (int i = 0; i < 9; i++)
            if (w[6:0] == OPS[i]) begin
                d.known = 1'b1;
                d.typ   = 4'(i);
            end
        if (!d.known) return d;
        d.f3  = w[14:12];
        d.rd  = (d.typ == 2 || d.typ == 6) ? 5'd0 : w[11:7];
        d.rs1 = (d.typ == 4 || d.typ == 5 || d.typ == 8) ? 5'd0 : w[19:15];
        d.rs2 = (d.typ == 2 || d.typ == 3 || d.typ == 6) ? w[24:20] : 5'd0;
        d.f7  = (d.typ == 3 || (d.typ == 1 && d.f3 == 3'd5)) ? w[30] : 1'b0;
        case (d.typ)
            4'd0, 4'd1, 4'd7: d.imm = 32'($signed(w[31:20]));
            4'd2:             d.imm = 32'($signed({w[31:25], w[11:7]}));
            4'd6:             d.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            4'd4, 4'd5:       d.imm = {w[31:12], 12'h000};
            4'd8:             d.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
            default:          d.imm = 32'd0;
        endcase
        return d;
    endfunction

    function automatic logic [22:0] cw_of(input dec_t d);
        return {d.rs2, d.rs1, d.rd, d.f7, d.f3, d.typ};
    endfunction

    function automatic logic writes(input dec_t d, input logic [4:0] r);
        return r != 5'd0 && d.typ != 4'd2 && d.typ != 4'd6 && d.rd == r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w        = $urandom;
        k        = $urandom_range(0, 19);
        w[24:20] = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[11:7]  = 5'($urandom_range(0, 7));
        w[6:0]   = (k == 18) ? 7'h7F : (k == 19) ? 7'h0B : OPS[k % 9];
        return w;
    endfunction

    task automatic compare();
        check("imem_addr", 32'(imem_addr), 32'(m_pc_if[9:2]));
        check("cwordID", 32'(cwordID), 32'(cw_of(ref_dec(m_id_w))));
        check("cwordEX", 32'(cwordEX), 32'(cw_of(ref_dec(m_ex_w))));
        check("cwordMEM", 32'(cwordMEM), 32'(cw_of(ref_dec(m_mem_w))));
        check("cwordWB", 32'(cwordWB), 32'(cw_of(ref_dec(m_wb_w))));
        check("immEX", immEX, ref_dec(m_ex_w).imm);
        check("immMEM", immMEM, ref_dec(m_mem_w).imm);
        check("illegal", 32'(illegal), 32'(m_ill));
        if (m_ex_v) check("pcEX", pc, m_ex_pc);
    endtask

    // One clock: drive inputs, predict the next state, then compare after the edge.
    task automatic step(input logic r, input logic [3:0] fl, input logic [31:0] rp);
        dec_t id, ex, mem, wb;
        logic redir, stall, taken, lt;
        logic [31:0] tgt, npc, nid, nidpc, nex, nexpc, nmem, nwb;
        logic nidv, nexv, nill;
        @(negedge clk);
        rst = r;
        funit_ZCNVFlags = fl;
        r_for_pc = rp;
        id  = ref_dec(m_id_w);
        ex  = ref_dec(m_ex_w);
        mem = ref_dec(m_mem_w);
        wb  = ref_dec(m_wb_w);
        lt  = fl[1] ^ fl[0];
        case (ex.f3)
            3'd0: taken = fl[3];
            3'd1: taken = !fl[3];
            3'd4: taken = lt;
            3'd5: taken = !lt;
            3'd6: taken = !fl[2];
            3'd7: taken = fl[2];
            default: taken = 1'b0;
        endcase
        redir = (ex.typ == 4'd6 && taken) || ex.typ == 4'd7 || ex.typ == 4'd8;
        tgt   = (ex.typ == 4'd7) ? ((rp + ex.imm) & 32'hFFFF_FFFE) : (m_ex_pc + ex.imm);
        stall = (ex.typ == 4'd0 && (writes(ex, id.rs1) || writes(ex, id.rs2))) ||
                (mem.typ == 4'd0 && (writes(mem, id.rs1) || writes(mem, id.rs2))) ||
                (id.typ == 4'd2 && (writes(ex, id.rs2) || writes(mem, id.rs2) || writes(wb, id.rs2))) ||
                (id.typ == 4'd7 && (writes(ex, id.rs1) || writes(mem, id.rs1) || writes(wb, id.rs1)));
        npc = m_pc_if; nid = m_id_w; nidpc = m_id_pc; nidv = m_id_v;
        nex = NOP; nexpc = m_id_pc; nexv = 1'b0;
        nmem = m_ex_w; nwb = m_mem_w;
        nill = !id.known && !redir;
        if (redir) begin
            npc = tgt; nid = NOP; nidv = 1'b0;
        end else if (!stall) begin
            nex   = id.known ? m_id_w : NOP;
            nexv  = m_id_v && id.known;
            nid   = imem[m_pc_if[9:2]];
            nidpc = m_pc_if;
            nidv  = 1'b1;
            npc   = m_pc_if + 32'd4;
        end
        if (!r) begin
            npc = 32'd0; nid = NOP; nidpc = 32'd0; nidv = 1'b0;
            nex = NOP; nexpc = 32'd0; nexv = 1'b0; nmem = NOP; nwb = NOP; nill = 1'b0;
        end
        @(posedge clk);
        #1;
        m_pc_if = npc; m_id_w = nid; m_id_pc = nidpc; m_id_v = nidv;
        m_ex_w = nex; m_ex_pc = nexpc; m_ex_v = nexv; m_mem_w = nmem; m_wb_w = nwb; m_ill = nill;
        compare();
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = NOP;
    endtask

    task automatic reset_dut(input logic [3:0] fl, input logic [31:0] rp);
        step(1'b0, fl, rp);
        step(1'b0, fl, rp);
    endtask

    initial begin
        rst = 1'b0;
        funit_ZCNVFlags = 4'd0;
        r_for_pc = 32'd0;
        m_pc_if = 0; m_id_w = NOP; m_id_pc = 0; m_id_v = 0;
        m_ex_w = NOP; m_ex_pc = 0; m_ex_v = 0; m_mem_w = NOP; m_wb_w = NOP; m_ill = 0;

        // Reset values and basic decode
        clear_imem();
        imem[0] = 32'hFFD0_8293;
        imem[1] = 32'h1234_51B7;
        reset_dut(4'd0, 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_cwordEX", 32'(cwordEX), 32'h1);
        check("rst_cwordWB", 32'(cwordWB), 32'h1);
        check("rst_pc", pc, 32'd0);
        check("rst_immEX", immEX, 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        step(1'b1, 4'd0, 32'd0);
        check("addi_cwordID", 32'(cwordID), 32'h2501);
        step(1'b1, 4'd0, 32'd0);
        check("addi_immEX", immEX, 32'hFFFF_FFFD);
        check("addi_pc", pc, 32'd0);
        check("lui_rs1", 32'(cwordID[17:13]), 32'd0);
        step(1'b1, 4'd0, 32'd0);
        check("lui_immEX", immEX, 32'h1234_5000);

        // Load-use: lw x2,0(x1); add x3,x2,x2
        clear_imem();
        imem[0] = 32'h0000_A103;
        imem[1] = 32'h0021_01B3;
        reset_dut(4'd0, 32'd0);
        step(1'b1, 4'd0, 32'd0);
        step(1'b1, 4'd0, 32'd0);
        step(1'b1, 4'd0, 32'd0);
        check("lu_hold1", 32'(imem_addr), 32'd2);
        step(1'b1, 4'd0, 32'd0);
        check("lu_hold2", 32'(imem_addr), 32'd2);
        check("lu_bubble", 32'(cwordEX), 32'h1);
        check("lu_lw_wb", 32'(cwordWB), 32'h2220);
        step(1'b1, 4'd0, 32'd0);
        check("lu_add_ex", 32'(cwordEX), 32'h8_4303);

        // beq x0,x0,+0x20 at 0x10, taken then not taken
        for (int pass = 0; pass < 2; pass++) begin
            logic [3:0] fl;
            fl = (pass == 0) ? 4'b1000 : 4'b0000;
            clear_imem();
            imem[4] = 32'h0200_0063;
            reset_dut(fl, 32'd0);
            for (int i = 0; i < 7; i++) step(1'b1, fl, 32'd0);
            check(pass == 0 ? "beq_taken_addr" : "beq_nt_addr", 32'(imem_addr), pass == 0 ? 32'd12 : 32'd7);
            if (pass == 0) check("beq_flush", 32'(cwordEX), 32'h1);
        end

        // addi x6,x0,5; jalr x1,8(x6) with r_for_pc = 0x101
        clear_imem();
        imem[0] = 32'h0050_0313;
        imem[1] = 32'h0083_00E7;
        reset_dut(4'd0, 32'h101);
        for (int i = 0; i < 5; i++) step(1'b1, 4'd0, 32'h101);
        check("jalr_hold", 32'(imem_addr), 32'd2);
        step(1'b1, 4'd0, 32'h101);
        check("jalr_in_ex", 32'(cwordEX[3:0]), 32'd7);
        check("jalr_pc", pc, 32'd4);
        step(1'b1, 4'd0, 32'h101);
        check("jalr_target", 32'(imem_addr), 32'h42);

        // Unknown opcode
        clear_imem();
        imem[0] = 32'h0000_007F;
        reset_dut(4'd0, 32'd0);
        step(1'b1, 4'd0, 32'd0);
        check("ill_early", 32'(illegal), 32'd0);
        step(1'b1, 4'd0, 32'd0);
        check("ill_pulse", 32'(illegal), 32'd1);
        check("ill_nop_ex", 32'(cwordEX), 32'h1);
        step(1'b1, 4'd0, 32'd0);
        check("ill_end", 32'(illegal), 32'd0);

        // Taken branch in EX while a dependent store sits in ID
        clear_imem();
        imem[2] = 32'h0010_0393;
        imem[3] = 32'h0200_0063;
        imem[4] = 32'h0070_2023;
        reset_dut(4'b1000, 32'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 4'b1000, 32'd0);
        check("rs_store_id", 32'(cwordID[3:0]), 32'd2);
        step(1'b1, 4'b1000, 32'd0);
        check("rs_redirect", 32'(imem_addr), 32'd11);
        check("rs_flush", 32'(cwordEX), 32'h1);

        // Random programs, flags, jalr bases and occasional resets
        for (int i = 0; i < 256; i++) imem[i] = rand_instr();
        reset_dut(4'd0, 32'd0);
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15)), $urandom);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
